// File: rtl/pspin_hostmem_pkg.sv
// ----------------------------------------------------------------------------
// pspin_hostmem_pkg
//
// Shared definitions for the PsPIN host-memory read path: AXI response and
// burst-type codes, plus the state encoding of the read-burst splitter FSM.
// ----------------------------------------------------------------------------
package pspin_hostmem_pkg;

    // AXI RRESP codes
    localparam logic [1:0] AXI_OKAY   = 2'b00;
    localparam logic [1:0] AXI_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_SLVERR = 2'b10;

    // AXI ARBURST codes
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // Splitter FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,  // waiting for an upstream AR
        ST_ISSUE = 2'd1,  // presenting one downstream sub-burst AR
        ST_DATA  = 2'd2,  // passing the sub-burst's R beats upstream
        ST_ERR   = 2'd3   // answering an unsupported request locally
    } rd_state_e;

endpackage

// File: rtl/pspin_hostmem_rd_len_calc.sv
// ----------------------------------------------------------------------------
// pspin_hostmem_rd_len_calc
//
// Combinational sub-burst length: the number of beats the next downstream
// burst may carry, limited by the beats still owed upstream, the maximum
// burst length and the distance to the next BOUNDARY-byte boundary.
//
// Ports
//   i_addr        current (beat-aligned) byte address of the next sub-burst
//   i_beats_left  beats still to be requested, 1..256
//   o_sub_beats   beats for the next sub-burst, 1..MAX_BURST_BEATS
// ----------------------------------------------------------------------------
module pspin_hostmem_rd_len_calc
    import pspin_hostmem_pkg::*;
#(
    parameter int ADDR_WIDTH      = 64,
    parameter int NUM_BYTES       = 64,
    parameter int MAX_BURST_BEATS = 16,
    parameter int BOUNDARY        = 4096
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [8:0]            i_beats_left,
    output logic [8:0]            o_sub_beats
);

    localparam int                    SIZE_LOG      = $clog2(NUM_BYTES);
    localparam logic [ADDR_WIDTH-1:0] BOUNDARY_MASK = ADDR_WIDTH'(BOUNDARY - 1);

    logic [31:0] w_bnd_off;
    logic [31:0] w_bnd_beats;
    logic [8:0]  w_bnd_cap;
    logic [8:0]  w_len_cap;

    always_comb begin
        w_bnd_off   = 32'(i_addr & BOUNDARY_MASK);
        w_bnd_beats = (32'(BOUNDARY) - w_bnd_off) >> SIZE_LOG;
        // A request never exceeds 256 beats, so saturating the boundary
        // distance there keeps the compare narrow without changing the result.
        w_bnd_cap   = (w_bnd_beats > 32'd256) ? 9'd256 : w_bnd_beats[8:0];
        w_len_cap   = (i_beats_left < 9'(MAX_BURST_BEATS)) ? i_beats_left
                                                           : 9'(MAX_BURST_BEATS);
        o_sub_beats = (w_len_cap < w_bnd_cap) ? w_len_cap : w_bnd_cap;
    end

endmodule

// File: rtl/pspin_hostmem_rd_splitter.sv
// ----------------------------------------------------------------------------
// pspin_hostmem_rd_splitter
//
// Upstream AXI read-burst conditioner. Splits an arbitrary INCR read into
// downstream sub-bursts of at most MAX_BURST_BEATS beats that never cross a
// BOUNDARY-byte boundary, and merges the returned R beats into one upstream
// response with a single RLAST. Narrow, unaligned or non-INCR requests are
// answered locally with SLVERR beats and never reach the downstream port.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   s_axi_ar*           upstream read-address channel (slave side)
//   s_axi_r*            upstream read-data channel (slave side)
//   m_axi_ar*           downstream read-address channel (master side);
//                       arsize fixed at log2(NUM_BYTES), arburst fixed INCR
//   m_axi_r*            downstream read-data channel (master side);
//                       m_axi_rid is ignored, m_axi_rlast is trusted
// ----------------------------------------------------------------------------
module pspin_hostmem_rd_splitter
    import pspin_hostmem_pkg::*;
#(
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 512,
    parameter int ID_WIDTH        = 8,
    parameter int MAX_BURST_BEATS = 16,
    parameter int BOUNDARY        = 4096
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,

    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,

    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam int                    NUM_BYTES  = DATA_WIDTH / 8;
    localparam int                    SIZE_LOG   = $clog2(NUM_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(NUM_BYTES - 1);

    rd_state_e             r_state;
    logic [ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    // Beats not yet requested downstream (ISSUE/DATA) or not yet returned (ERR).
    logic [8:0]            r_beats_left;
    logic                  r_arready;
    logic                  r_arvalid;
    logic                  r_err_rvalid;

    logic [8:0]            w_sub_beats;
    logic                  w_up_ar_hs;
    logic                  w_req_legal;
    logic                  w_dn_ar_hs;
    logic                  w_dn_last_hs;
    logic                  w_err_hs;
    logic                  w_unused;

    pspin_hostmem_rd_len_calc #(
        .ADDR_WIDTH      (ADDR_WIDTH),
        .NUM_BYTES       (NUM_BYTES),
        .MAX_BURST_BEATS (MAX_BURST_BEATS),
        .BOUNDARY        (BOUNDARY)
    ) u_len_calc (
        .i_addr       (r_addr),
        .i_beats_left (r_beats_left),
        .o_sub_beats  (w_sub_beats)
    );

    assign w_up_ar_hs   = s_axi_arvalid && r_arready;
    assign w_req_legal  = (s_axi_arsize == 3'(SIZE_LOG))
                       && (s_axi_arburst == BURST_INCR)
                       && ((s_axi_araddr & ALIGN_MASK) == '0);
    assign w_dn_ar_hs   = r_arvalid && m_axi_arready;
    assign w_dn_last_hs = (r_state == ST_DATA) && m_axi_rvalid && s_axi_rready && m_axi_rlast;
    assign w_err_hs     = r_err_rvalid && s_axi_rready;

    // Downstream RID carries nothing this block needs; the latched id is used.
    assign w_unused = ^m_axi_rid;

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_id         <= '0;
            r_addr       <= '0;
            r_beats_left <= '0;
            r_arready    <= 1'b0;
            r_arvalid    <= 1'b0;
            r_err_rvalid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_up_ar_hs) begin
                        r_id         <= s_axi_arid;
                        r_addr       <= s_axi_araddr;
                        r_beats_left <= {1'b0, s_axi_arlen} + 9'd1;
                        r_arready    <= 1'b0;
                        if (w_req_legal) begin
                            r_state   <= ST_ISSUE;
                            r_arvalid <= 1'b1;
                        end else begin
                            r_state      <= ST_ERR;
                            r_err_rvalid <= 1'b1;
                        end
                    end else begin
                        // Also raises arready in the first cycle out of reset.
                        r_arready <= 1'b1;
                    end
                end

                ST_ISSUE: begin
                    // Address and length are held until the handshake, so
                    // the combinational arlen stays stable while arvalid is up.
                    if (w_dn_ar_hs) begin
                        r_arvalid    <= 1'b0;
                        r_addr       <= r_addr + (ADDR_WIDTH'(w_sub_beats) << SIZE_LOG);
                        r_beats_left <= r_beats_left - w_sub_beats;
                        r_state      <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (w_dn_last_hs) begin
                        if (r_beats_left == 9'd0) begin
                            r_state   <= ST_IDLE;
                            r_arready <= 1'b1;
                        end else begin
                            r_state   <= ST_ISSUE;
                            r_arvalid <= 1'b1;
                        end
                    end
                end

                ST_ERR: begin
                    if (w_err_hs) begin
                        r_beats_left <= r_beats_left - 9'd1;
                        if (r_beats_left == 9'd1) begin
                            r_state      <= ST_IDLE;
                            r_err_rvalid <= 1'b0;
                            r_arready    <= 1'b1;
                        end
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s_axi_arready = r_arready;

    assign m_axi_arvalid = r_arvalid;
    assign m_axi_arid    = r_id;
    assign m_axi_araddr  = r_addr;
    assign m_axi_arlen   = 8'(w_sub_beats - 9'd1);
    assign m_axi_arsize  = 3'(SIZE_LOG);
    assign m_axi_arburst = BURST_INCR;

    // R path: zero-latency pass-through in DATA, locally generated in ERR.
    // NOTE: every output gets a default before the case, so no path through
    // this block can leave a value unassigned and infer a latch.
    always_comb begin
        s_axi_rid    = r_id;
        s_axi_rvalid = r_err_rvalid;
        s_axi_rdata  = '0;
        s_axi_rresp  = AXI_OKAY;
        s_axi_rlast  = 1'b0;
        m_axi_rready = 1'b0;
        case (r_state)
            ST_DATA: begin
                s_axi_rvalid = m_axi_rvalid;
                s_axi_rdata  = m_axi_rdata;
                s_axi_rresp  = m_axi_rresp;
                // Only the last sub-burst's rlast closes the upstream burst.
                s_axi_rlast  = m_axi_rlast && (r_beats_left == 9'd0);
                m_axi_rready = s_axi_rready;
            end
            ST_ERR: begin
                s_axi_rresp = AXI_SLVERR;
                s_axi_rlast = (r_beats_left == 9'd1);
            end
            default: ;
        endcase
    end

endmodule

// File: doc/pspin_hostmem_rd_splitter.md
# pspin_hostmem_rd_splitter

Upstream AXI read-burst conditioner for the PsPIN host-memory DMA read datapath. Accepts arbitrary-length INCR reads from the PsPIN host-memory AXI port and re-issues them as sub-bursts that never exceed `MAX_BURST_BEATS` and never cross a `BOUNDARY`-byte address boundary. It merges the downstream R beats back into a single response stream with one `rlast`. Unsupported requests (narrow, unaligned, non-INCR) are answered locally with SLVERR beats, so the downstream read datapath only ever sees legal full-width aligned bursts.

## Interface
- `ADDR_WIDTH`, 64, AXI address width
- `DATA_WIDTH`, 512, AXI data width; `NUM_BYTES = DATA_WIDTH/8`
- `ID_WIDTH`, 8, AXI ID width
- `MAX_BURST_BEATS`, 16, maximum beats per sub-burst; power of 2, 1..256
- `BOUNDARY`, 4096, byte boundary that a sub-burst must not cross; power of 2, ≥ `NUM_BYTES`
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `s_axi_arid/araddr/arlen/arsize/arburst`  in  ID_WIDTH/ADDR_WIDTH/8/3/2  upstream AR payload
- `s_axi_arvalid`  in  1; `s_axi_arready`  out  1  upstream AR handshake
- `s_axi_rid/rdata/rresp/rlast`  out  ID_WIDTH/DATA_WIDTH/2/1  upstream R payload
- `s_axi_rvalid`  out  1; `s_axi_rready`  in  1  upstream R handshake
- `m_axi_arid/araddr/arlen`  out  ID_WIDTH/ADDR_WIDTH/8  downstream AR; `m_axi_arsize` is constant `log2(NUM_BYTES)`, `m_axi_arburst` is constant INCR
- `m_axi_arvalid`  out  1; `m_axi_arready`  in  1  downstream AR handshake
- `m_axi_rid/rdata/rresp/rlast`  in  ID_WIDTH/DATA_WIDTH/2/1  downstream R payload
- `m_axi_rvalid`  in  1; `m_axi_rready`  out  1  downstream R handshake

## Operation
- **FSM states:** IDLE, ISSUE, DATA, ERR.
- **IDLE:**
  - `s_axi_arready` = 1.
  - On an AR handshake, latch id, addr, and `beats_left = arlen+1` (9 bits).
  - The request is legal when `arsize == log2(NUM_BYTES)`, `arburst == INCR`, and `araddr % NUM_BYTES == 0`.
  - Legal request goes to ISSUE; illegal request goes to ERR.
- **ISSUE:**
  - Drive `m_axi_arvalid` = 1 with the latched id and current address.
  - `m_axi_arlen = sub_beats - 1`, where `sub_beats = min(beats_left, MAX_BURST_BEATS, (BOUNDARY - addr % BOUNDARY)/NUM_BYTES)`.
  - Payload stays stable while `arvalid` is high.
  - On handshake: `addr += sub_beats*NUM_BYTES`, `beats_left -= sub_beats`, go to DATA.
- **DATA:**
  - Combinational pass-through: `s_axi_rvalid = m_axi_rvalid`, `m_axi_rready = s_axi_rready`, and `rdata`/`rresp` pass through per beat.
  - `s_axi_rid` = latched id.
  - `s_axi_rlast = m_axi_rlast && beats_left == 0`.
  - On an `m_axi_rlast` handshake: `beats_left == 0` goes to IDLE, otherwise to ISSUE.
- **ERR:**
  - Emit `arlen+1` beats with `rvalid` = 1, `rresp` = SLVERR (2'b10), `rdata` = 0, `rid` = latched id, and `rlast` on the final beat.
  - A beat counter decrements on each R handshake; the final handshake goes to IDLE.
  - No downstream AR is issued for an illegal request.
- Only one upstream request and one downstream sub-burst are outstanding at a time.
- Downstream `m_axi_rid` is ignored.
- Downstream `rlast` is trusted: the block does not count beats in DATA.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap is not checked.

## Timing
- **Reset values:**
  - `s_axi_arready`, `m_axi_arvalid`, `s_axi_rvalid` (ERR path), `m_axi_rready` = 0.
  - All registered payloads = 0.
  - FSM in IDLE.
  - `s_axi_arready` rises in the first cycle after reset is released.
- **Latency:**
  - Upstream AR handshake at cycle N → `m_axi_arvalid` = 1 at cycle N+1.
  - Sub-burst end at cycle M → next `m_axi_arvalid` = 1 at cycle M+1.
  - Sub-burst end at cycle M with nothing remaining → `s_axi_arready` = 1 at cycle M+1.
- The R path adds zero cycles of latency and has no buffering.
- `s_axi_arready` is 0 in every state except IDLE.
- `m_axi_rready` is 0 outside DATA.
- Reset asserted mid-burst: all state clears immediately; in-flight beats are dropped.

## Structure
- **Shared package `pspin_hostmem_pkg`:** AXI_OKAY, AXI_SLVERR, BURST_INCR, and the FSM state encoding.
- **Sub-module `pspin_hostmem_rd_len_calc`:** combinational `sub_beats` computation from addr, `beats_left`, `MAX_BURST_BEATS`, and `BOUNDARY`. Unit-testable in isolation.

## Test plan
- **Aligned short burst:** addr 0x1000, arlen 3 → one downstream AR, addr 0x1000, arlen 3. Four beats pass through with data and resp unchanged; `rlast` on beat 4.
- **Long burst:** addr 0x0, arlen 39, MAX 16 → downstream arlen 15/15/7 at addr 0x0/0x400/0x800. Upstream sees 40 beats with `rlast` only on beat 40.
- **Boundary cross:** addr 0xFC0, arlen 3 → arlen 0 at 0xFC0, then arlen 2 at 0x1000.
- **Illegal requests:** arsize 2, arlen 3 → no `m_axi_arvalid`; 4 SLVERR beats with zero data and `rlast` on beat 4. Unaligned addr 0x1004 and FIXED burst behave the same.
- **Backpressure:** random `s_axi_rready`/`m_axi_arready` stalls on the long burst → AR payload stable while stalled; no beat lost or duplicated; `s_axi_arready` = 1 exactly one cycle after the final beat.
- **Reset mid-burst:** `rst` asserted during sub-burst 2 → outputs at reset values; the next legal AR is accepted and completes normally.
